calc_entry_fsm: RTL

//  Operand/operator entry FSM; sits directly downstream of keyb_decoder.

---
 rtl/calc_entry_fsm.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/calc_entry_fsm.sv
// Operand/operator entry FSM: builds decimal operands A/B from key strobes, issues ALU start on '='.
// Latency: every register update is visible one cycle after the qualifying strobe.
// Backpressure: none; keys arriving while a result is pending are dropped.
module calc_entry_fsm #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_pressed,
    input  logic             is_num,
    input  logic             is_op,
    input  logic             is_eq,
    input  logic [3:0]       num_val,
    input  logic [1:0]       op_val,
    input  logic             result_valid,
    input  logic [WIDTH-1:0] result_in,
    input  logic             result_err,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [1:0]       op_code,
    output logic             start,
    output logic [WIDTH-1:0] display_val,
    output logic [1:0]       state_out,
    output logic             entry_err
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        WAIT_RES = 2'd2,
        SHOW_RES = 2'd3
    } state_t;

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_a, w_a;
    logic [WIDTH-1:0] r_b, w_b;
    logic [1:0]       r_op, w_op;
    logic             r_start, w_start;
    logic             r_err, w_err;
    logic [CW-1:0]    r_cnt_a, w_cnt_a;
    logic [CW-1:0]    r_cnt_b, w_cnt_b;

    logic             w_key_eq, w_key_op, w_key_num;
    logic [WIDTH-1:0] w_acc_a, w_acc_b;

    // Key decode: '=' beats operator beats digit; out-of-range digits never qualify.
    assign w_key_eq  = btn_pressed && is_eq;
    assign w_key_op  = btn_pressed && !is_eq && is_op;
    assign w_key_num = btn_pressed && !is_eq && !is_op && is_num && (num_val <= 4'd9);

    // X*10 + digit; the low WIDTH bits of a modular product equal a wider product truncated.
    assign w_acc_a = (r_a * WIDTH'(10)) + WIDTH'(num_val);
    assign w_acc_b = (r_b * WIDTH'(10)) + WIDTH'(num_val);

    // Next-state and next-register values.
    always_comb begin
        w_state = r_state;
        w_a     = r_a;
        w_b     = r_b;
        w_op    = r_op;
        w_start = 1'b0;
        w_err   = r_err;
        w_cnt_a = r_cnt_a;
        w_cnt_b = r_cnt_b;
        case (r_state)
            ENTER_A: begin
                if (w_key_num) begin
                    if (r_cnt_a == CNT_MAX) begin
                        w_err = 1'b1;
                    end else begin
                        w_a     = w_acc_a;
                        w_cnt_a = r_cnt_a + 1'b1;
                    end
                end else if (w_key_op) begin
                    w_op    = op_val;
                    w_b     = '0;
                    w_cnt_b = '0;
                    w_state = ENTER_B;
                end
            end
            ENTER_B: begin
                if (w_key_num) begin
                    if (r_cnt_b == CNT_MAX) begin
                        w_err = 1'b1;
                    end else begin
                        w_b     = w_acc_b;
                        w_cnt_b = r_cnt_b + 1'b1;
                    end
                end else if (w_key_op) begin
                    w_op = op_val;
                end else if (w_key_eq && (r_cnt_b != '0)) begin
                    w_start = 1'b1;
                    w_state = WAIT_RES;
                end
            end
            WAIT_RES: begin
                // Operands are frozen here; a simultaneous key is simply lost.
                if (result_valid) begin
                    w_a     = result_in;
                    w_cnt_a = '0;
                    w_err   = r_err | result_err;
                    w_state = SHOW_RES;
                end
            end
            SHOW_RES: begin
                if (w_key_num) begin
                    w_a     = WIDTH'(num_val);
                    w_cnt_a = CW'(1);
                    w_b     = '0;
                    w_err   = 1'b0;
                    w_state = ENTER_A;
                end else if (w_key_op) begin
                    w_op    = op_val;
                    w_b     = '0;
                    w_cnt_b = '0;
                    w_state = ENTER_B;
                end
            end
            default: w_state = ENTER_A;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ENTER_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            r_state <= w_state;
            r_a     <= w_a;
            r_b     <= w_b;
            r_op    <= w_op;
            r_start <= w_start;
            r_err   <= w_err;
            r_cnt_a <= w_cnt_a;
            r_cnt_b <= w_cnt_b;
        end
    end

    assign operand_a   = r_a;
    assign operand_b   = r_b;
    assign op_code     = r_op;
    assign start       = r_start;
    assign entry_err   = r_err;
    assign state_out   = r_state;
    // B is shown only while it is actually being typed.
    assign display_val = ((r_state == ENTER_B) && (r_cnt_b != '0)) ? r_b : r_a;

endmodule
